// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle, 34-cycle latency, result delivered on a register-file write port.
// Optional signed operation (op[2]) is built only when MDU_SIGNED_EN is defined.
module mdu_iter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] rd,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd
);

  localparam int unsigned CW = $clog2(DW) + 1;
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_next;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [DW:0]   rem_q, rem_d;
  logic [DW-1:0] opb_q, opb_d;
  logic          busy_d, done_d, we_d;
  logic [AW-1:0] wa_d;
  logic [DW-1:0] wd_d;

  logic [DW-1:0] a_mag, b_mag;
  logic [PW-1:0] acc_fix;
  logic [DW-1:0] rem_fix;
  logic [DW:0]   mul_sum;
  logic [DW+1:0] div_trial;
  logic [DW:0]   div_shift;
  logic          div_borrow;
  logic [DW-1:0] result;

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg, neg_q, negr_q;

  assign a_neg = op[2] & a[DW-1];
  assign b_neg = op[2] & b[DW-1];
  assign a_mag = a_neg ? (~a + DW'(1)) : a;
  assign b_mag = b_neg ? (~b + DW'(1)) : b;

  // Result signs are decided at acceptance; a zero divisor keeps the all-ones quotient unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q  <= (a_neg ^ b_neg) & ~(op[1] & (b == '0));
      negr_q <= a_neg;
    end
  end

  assign acc_fix = neg_q  ? (~acc_q + PW'(1)) : acc_q;
  assign rem_fix = negr_q ? (~rem_q[DW-1:0] + DW'(1)) : rem_q[DW-1:0];
`else
  logic unused_sign;

  assign unused_sign = op[2];
  assign a_mag       = a;
  assign b_mag       = b;
  assign acc_fix     = acc_q;
  assign rem_fix     = rem_q[DW-1:0];
`endif

  // Shift-add step: accumulator high half gains the multiplicand when the current multiplier bit is set.
  assign mul_sum    = {1'b0, acc_q[PW-1:DW]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  // Restoring-division step: the extra top bit of the trial difference is the borrow.
  assign div_trial  = {rem_q, acc_q[DW-1]} - {2'b00, opb_q};
  assign div_shift  = {rem_q[DW-1:0], acc_q[DW-1]};
  assign div_borrow = div_trial[DW+1];

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = acc_fix[DW-1:0];
      2'b01:   result = acc_fix[PW-1:DW];
      2'b10:   result = acc_fix[DW-1:0];
      default: result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    op_d       = op_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    wa_d       = wa;
    wd_d       = wd;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          op_d       = op[1:0];
          rd_d       = rd;
          cnt_d      = '0;
          rem_d      = '0;
          acc_d      = {{DW{1'b0}}, (op[1] ? a_mag : b_mag)};
          opb_d      = op[1] ? b_mag : a_mag;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          acc_d = {acc_q[PW-1:DW], acc_q[DW-2:0], ~div_borrow};
          rem_d = div_borrow ? div_shift : div_trial[DW:0];
        end else begin
          acc_d = {mul_sum, acc_q[DW-1:1]};
        end
        if (cnt_q == CW'(DW - 1)) state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
        done_d     = 1'b1;
        we_d       = (rd_q != '0);
        wa_d       = rd_q;
        wd_d       = result;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_d = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      opb_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
    end else begin
      op_q  <= op_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      opb_q <= opb_d;
      busy  <= busy_d;
      done  <= done_d;
      we    <= we_d;
      wa    <= wa_d;
      wd    <= wd_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table plus start-while-busy, back-to-back and mid-operation reset sequences.
// Expected signed-op results follow MDU_SIGNED_EN.
module tb_mdu_iter;

`ifdef MDU_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy, done, we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;
  int wcount = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  mdu_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we) wcount <= wcount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 into cycle 0; returns #1 into cycle 35 with start low.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [4:0] r, input logic [31:0] exp,
                       input bit inject);
    int bad_busy = 0;
    int bad_pulse = 0;
    start = 1'b1; op = o; a = aa; b = bb; rd = r;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      if (inject) begin
        start = (k == 5 || k == 34);
        if (start) begin op = 3'b000; a = 32'hDEAD_BEEF; b = 32'd3; rd = 5'd9; end
      end
      if (k <= 34 && busy !== 1'b1) bad_busy++;
      if (k < 34 && (done !== 1'b0 || we !== 1'b0)) bad_pulse++;
      if (k == 34) begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_we"},   32'(we),   32'(r != 5'd0));
        chk({tag, "_wa"},   32'(wa),   32'(r));
        chk({tag, "_wd"},   wd,        exp);
      end
      if (k == 35) begin
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_hold_wd"},   wd,        exp);
      end
      if (k < 35) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    chk({tag, "_busy_window"}, 32'(bad_busy), 32'd0);
    chk({tag, "_early_pulse"}, 32'(bad_pulse), 32'd0);
  endtask

  initial begin
    int wc0;
    vecs[0]  = '{3'b000, 32'h0001_2345, 32'h0000_1000, 5'd7,  32'h1234_5000};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
    vecs[2]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0001};
    vecs[3]  = '{3'b010, 32'd100,       32'd7,         5'd3,  32'd14};
    vecs[4]  = '{3'b011, 32'd100,       32'd7,         5'd4,  32'd2};
    vecs[5]  = '{3'b010, 32'h0000_0055, 32'd0,         5'd5,  32'hFFFF_FFFF};
    vecs[6]  = '{3'b011, 32'h0000_0055, 32'd0,         5'd6,  32'h0000_0055};
    vecs[7]  = '{3'b001, 32'h8000_0000, 32'd4,         5'd8,  32'h0000_0002};
    vecs[8]  = '{3'b000, 32'd7,         32'd6,         5'd0,  32'd42};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, SIGNED ? 32'hFFFF_FFFD : 32'h7FFF_FFFC};
    vecs[10] = '{3'b111, 32'hFFFF_FFF9, 32'd2,         5'd11, SIGNED ? 32'hFFFF_FFFF : 32'h0000_0001};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, SIGNED ? 32'h8000_0000 : 32'h0000_0000};
    vecs[12] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, SIGNED ? 32'h0000_0000 : 32'h8000_0000};
    vecs[13] = '{3'b101, 32'hFFFF_FFF9, 32'd3,         5'd14, SIGNED ? 32'hFFFF_FFFF : 32'h0000_0002};
    vecs[14] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFFF};
    vecs[15] = '{3'b111, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFF9};
    vecs[16] = '{3'b111, 32'd100,       32'hFFFF_FFF9, 5'd17, SIGNED ? 32'h0000_0002 : 32'h0000_0064};
    vecs[17] = '{3'b110, 32'd100,       32'hFFFF_FFF9, 5'd18, SIGNED ? 32'hFFFF_FFF2 : 32'h0000_0000};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we",   32'(we),   32'd0);
    chk("rst_wa",   32'(wa),   32'd0);
    chk("rst_wd",   wd,        32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b0);
    end

    // Starts in cycles 5 and 34 must be dropped; the following op is accepted in cycle 35.
    wc0 = wcount;
    do_op("ignore", 3'b010, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    chk("ignore_one_write", 32'(wcount - wc0), 32'd1);
    do_op("b2b", 3'b000, 32'd3, 32'd5, 5'd20, 32'd15, 1'b0);
    chk("b2b_writes", 32'(wcount - wc0), 32'd2);

    // Reset in cycle 20 aborts the operation with no write.
    wc0 = wcount;
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9; rd = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we",   32'(we),   32'd0);
    chk("abort_wa",   32'(wa),   32'd0);
    chk("abort_wd",   wd,        32'd0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort_no_write", 32'(wcount - wc0), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit in the execute/writeback path next to the 32×32 register file. It consumes two operands read from the register file and a destination index. It computes a 32-bit product half, quotient or remainder over a fixed number of cycles, one bit per cycle. The result is presented on a write port (`we`/`wa`/`wd`) that connects directly to the register file's synchronous write port.

## Interface
- `AW`, 5, destination register index width.
- `DW`, 32, operand/result width; the iteration count equals `DW`.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 3: operation select.
  - `op[1:0]`: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder).
  - `op[2]`: signed select; only meaningful with `MDU_SIGNED_EN`.
- `a` input DW: operand A (multiplicand / dividend).
- `b` input DW: operand B (multiplier / divisor).
- `rd` input AW: destination register index.
- `busy` output 1: unit occupied; high from the cycle after acceptance through the DONE cycle.
- `done` output 1: one-cycle completion pulse.
- `we` output 1: register-file write enable, high in the DONE cycle only if the latched `rd`≠0.
- `wa` output AW: register-file write address (latched `rd`).
- `wd` output DW: result.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE→CALC on `start`=1. Latch `op`, `rd`, `a`, `b`; clear the iteration counter.
  - CALC→FIX after `DW` iterations.
  - FIX→DONE unconditionally.
  - DONE→IDLE unconditionally.
- MUL/MULH: shift-add over a 2·DW accumulator. MUL returns bits [DW-1:0]; MULH returns bits [2DW-1:DW].
- DIV/REM: restoring division, one quotient bit per CALC cycle. The remainder register is DW+1 bits so the trial subtraction produces a borrow.
- Divide by zero (`b`=0): quotient = all ones (0xFFFFFFFF), remainder = `a`. The 32 CALC cycles still elapse, so latency is constant.
- FIX applies sign correction (signed build) and selects the result into `wd`. It is otherwise a pass-through stage.
- `start` while `busy`=1 is ignored: no operand sampling, no queuing.
- `rd`=0: `done` pulses, `we` stays 0, and `wd`/`wa` update normally.
- `wa`/`wd` are registered and hold their values after DONE until the next DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `we`=0, `wa`=0, `wd`=0, counter 0.
- `rst` mid-operation: abort to IDLE next edge. No write is issued and the latched operation is discarded.

## Timing
- Start is sampled at the rising edge that ends cycle 0.
- CALC occupies cycles 1–32, FIX cycle 33, DONE cycle 34.
- `busy`=1 in cycles 1–34. `done`=`we`=1 in cycle 34 only.
- Earliest next acceptance: `start` in cycle 35, because `busy` is still 1 in cycle 34.
- Fixed latency of 34 cycles from acceptance to write, independent of operand values.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The register file captures `wd` at the edge ending cycle 34.

## Configuration
- `MDU_SIGNED_EN` defined: `op[2]`=1 selects signed semantics.
  - Operand magnitudes are taken at acceptance and the result sign is fixed in FIX.
  - MULH returns the high half of the signed×signed product.
  - DIV truncates toward zero; REM takes the sign of the dividend.
  - Overflow case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Signed divide by zero: quotient 0xFFFFFFFF, remainder = `a`.
- `MDU_SIGNED_EN` undefined: `op[2]` is ignored and all operations are unsigned. No sign logic is synthesized.
- Latency is identical in both builds.

## Test plan
- MUL, `a`=0x00012345, `b`=0x00001000, `rd`=7, reset released → `wd`=0x12345000, `wa`=7, `we`=`done`=1 exactly in cycle 34, `busy` high in cycles 1–34.
- MULH unsigned, `a`=`b`=0xFFFFFFFF → `wd`=0xFFFFFFFE. MUL with the same operands → `wd`=0x00000001.
- DIV/REM, `a`=100, `b`=7 → 14 and 2. DIV with `b`=0, `a`=0x55 → 0xFFFFFFFF; REM → 0x55. Latency is still 34 cycles.
- Pulse `start` in cycles 5 and 34 during an operation, with different operands → both ignored, exactly one write. A `start` in cycle 35 is accepted and completes in cycle 69.
- `rd`=0 → `done` pulses, `we`=0. Assert `rst` in cycle 20 → next cycle `busy`=`done`=`we`=0, `wa`=`wd`=0, and no write follows.
- Signed build: DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF → 0x80000000 with REM 0. Unsigned build with `op[2]`=1 → unsigned results.
